// File: rtl/delay_var.sv
// delay_var: runtime-adjustable {valid,data} delay line with stall, flush and fill tracking.
// Optional DELAY_VAR_OUT_REG_EN adds a registered output stage after the length mux.
module delay_var #(
  parameter  int DATA_WIDTH = 16,
  parameter  int MAX_LENGTH = 8,
  localparam int LEN_W      = $clog2(MAX_LENGTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  flush,
  input  logic [LEN_W-1:0]      len_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  fill_o,
  output logic [LEN_W-1:0]      len_o
);

  localparam int IDX_W = $clog2(MAX_LENGTH);

  typedef enum logic {FILL, RUN} state_t;

  state_t                  state;
  logic [LEN_W-1:0]        cnt;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        len_sat;
  logic [LEN_W-1:0]        last;
  logic                    restart;
  logic [IDX_W-1:0]        tap;
  logic [MAX_LENGTH-1:0]   v_q;
  logic [DATA_WIDTH-1:0]   d_q [MAX_LENGTH];
  logic                    mux_v;
  logic [DATA_WIDTH-1:0]   mux_d;

  always_comb begin
    len_sat = len_i;
    if (len_i == '0)
      len_sat = LEN_W'(1);
    else if (len_i > LEN_W'(MAX_LENGTH))
      len_sat = LEN_W'(MAX_LENGTH);
  end

  // A length change behaves exactly like a flush
  assign restart = flush | (len_sat != len_q);

  assign tap   = IDX_W'(len_q - LEN_W'(1));
  assign mux_v = v_q[tap];
  assign mux_d = d_q[tap];

`ifdef DELAY_VAR_OUT_REG_EN
  assign last = len_q;
`else
  assign last = len_q - LEN_W'(1);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q <= '0;
      for (int k = 0; k < MAX_LENGTH; k++)
        d_q[k] <= '0;
    end else if (restart) begin
      v_q <= '0;
    end else if (ce) begin
      v_q    <= {v_q[MAX_LENGTH-2:0], valid_i};
      d_q[0] <= data_i;
      for (int k = 1; k < MAX_LENGTH; k++)
        d_q[k] <= d_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FILL;
      cnt   <= '0;
      len_q <= LEN_W'(MAX_LENGTH);
    end else begin
      len_q <= len_sat;
      if (restart) begin
        state <= FILL;
        cnt   <= '0;
      end else if (ce && state == FILL) begin
        cnt <= cnt + LEN_W'(1);
        if (cnt == last)
          state <= RUN;
      end
    end
  end

`ifdef DELAY_VAR_OUT_REG_EN
  logic                  vo_q;
  logic [DATA_WIDTH-1:0] do_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vo_q <= 1'b0;
      do_q <= '0;
    end else if (restart) begin
      vo_q <= 1'b0;
    end else if (ce) begin
      vo_q <= mux_v;
      do_q <= mux_d;
    end
  end

  assign valid_o = vo_q;
  assign data_o  = do_q;
`else
  assign valid_o = mux_v;
  assign data_o  = mux_d;
`endif

  assign fill_o = (state == FILL);
  assign len_o  = len_q;

endmodule

// File: doc/delay_var.md
# delay_var

Runtime-adjustable delay line for data words, each paired with a valid flag. It delays each word by 1..MAX_LENGTH clock-enabled cycles and supports stall, flush and on-the-fly length changes. It extends the fixed-length delay primitive and is used to align datapaths whose latency is set by configuration registers, for example in the rounder pipeline. A fill state machine reports when the output stream is meaningful after reset, flush or a length change.

## Interface
- DATA_WIDTH, 16, width of data_i/data_o
- MAX_LENGTH, 8, maximum delay in stages (≥2)
- LEN_W, $clog2(MAX_LENGTH+1), width of len_i (derived; not to be overridden)

- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-low reset (asserted when 0)
- ce  input  1  clock enable; 0 freezes the whole pipeline (stall)
- flush  input  1  clears all in-flight valids and restarts fill
- len_i  input  LEN_W  requested delay; 0 is treated as 1, values >MAX_LENGTH saturate to MAX_LENGTH
- valid_i  input  1  input word qualifier
- data_i  input  DATA_WIDTH  input word
- valid_o  output  1  output word qualifier
- data_o  output  DATA_WIDTH  delayed word
- fill_o  output  1  high while the pipeline is refilling (FILL state)
- len_o  output  LEN_W  currently applied (saturated) length len_q

## Operation
- Storage: MAX_LENGTH stages of {valid, data}. On a ce cycle, stage 0 ← {valid_i, data_i} and stage k ← stage k-1.
- Output: {valid_o, data_o} = stage[len_q-1].
- len_q is sampled every cycle, independent of ce. If sat(len_i) ≠ len_q: len_q ← sat(len_i), all stage valids ← 0, state ← FILL, cnt ← 0. This is a length-change flush. Data bits are not cleared.
- flush=1: all stage valids ← 0, state ← FILL, cnt ← 0. The input on that cycle is discarded even if ce=1.
- A length change and flush in the same cycle act as a single flush with the new length applied.
- FSM with two states:
  - FILL: on each ce cycle, cnt ← cnt+1. When cnt == len_q-1 and ce=1, go to RUN.
  - RUN: hold. Leave RUN only on flush, length change or reset.
- fill_o = (state == FILL).
- ce=0: stages, cnt and state are frozen. Flush and length change still take effect.
- Reset (rst=0): all stage valids and data ← 0, len_q ← MAX_LENGTH, state ← FILL, cnt ← 0. Reset overrides ce, flush and length change.
- Reset values of outputs: valid_o=0, data_o=0, fill_o=1, len_o=MAX_LENGTH.
- Bubbles (valid_i=0) propagate as bubbles. valid_o is never asserted for a word that entered before the latest flush or length change.

## Timing
- Latency with ce held high: a word presented in cycle t appears on data_o in cycle t+len_q. For len_q=1 this is one register.
- With stalls, latency is len_q ce-cycles.
- After a flush or length change at edge f, with ce continuously high: fill_o drops after edge f+len_q. The first post-flush word (entered at edge f+1) appears valid in that same cycle.
- Length change takes effect on the output on the cycle after the edge that samples it.
- Throughput: one word per ce cycle; no backpressure output.

## Configuration
- DELAY_VAR_OUT_REG_EN defined: adds a registered output stage after the len_q mux, with the same ce, flush and reset behaviour. This adds 1 to all latencies and to the fill count (FILL lasts len_q+1 ce-cycles). The output register's valid is cleared on flush or length change.
- DELAY_VAR_OUT_REG_EN undefined: valid_o/data_o are a combinational mux of the stage registers, and latency is exactly as stated above.

## Test plan
- Reset, then len_i=3, ce=1, valid_i=1, data_i=1,2,3,… → fill_o high for 3 cycles after the length change; data_o=1 valid exactly 3 cycles after 1 was input; stream continues in order with no gaps.
- len_i=0 and len_i=MAX_LENGTH+5 → len_o=1 and len_o=MAX_LENGTH respectively; measured latencies are 1 and MAX_LENGTH.
- len=4 stream, ce toggled 1,0,1,0,… → output order preserved, latency 4 ce-cycles, data_o/valid_o stable during ce=0.
- len=4, flush asserted mid-stream together with valid_i=1, data_i=0xAAAA → 0xAAAA never appears; valid_o=0 for 4 cycles; the next word appears valid when fill_o falls.
- Change len 4→2 while running → no pre-change word appears valid; new words have 2-cycle latency.
- Assert rst=0 mid-stream with ce=0 and flush=1 → after the edge, valid_o=0, data_o=0, fill_o=1, len_o=MAX_LENGTH.
- Repeat all scenarios with DELAY_VAR_OUT_REG_EN defined → every latency is +1.
